// File: rtl/fifo_wr_req.sv
// Write-side initiator for the FIFO acknowledgement handshake.
// Requests access, then streams a paced burst while tracking the write pointer.
module fifo_wr_req #(
    parameter int DATASIZE  = 8,
    parameter int ADDRSIZE  = 10,
    parameter int BURST_LEN = 1024
) (
    input  logic                wclk,
    input  logic                wrst_n,
    input  logic                start,
    input  logic [1:0]          widle_cfg,
    input  logic                wack,
    input  logic                wfull,
    output logic                wen,
    output logic [1:0]          widle,
    output logic                winc,
    output logic [ADDRSIZE-1:0] waddr,
    output logic [ADDRSIZE:0]   wptr,
    output logic [DATASIZE-1:0] wdata,
    output logic                busy,
    output logic                done
);

    typedef enum logic [2:0] {
        IDLE,
        REQ,
        WRITE,
        GAP,
        DONE
    } state_t;

    localparam logic [ADDRSIZE:0] LAST = (ADDRSIZE+1)'(BURST_LEN - 1);

    state_t            state, state_nx;
    logic [ADDRSIZE:0] cnt, cnt_nx;
    logic [1:0]        gap, gap_nx;
    logic [1:0]        widle_nx;
    logic              winc_nx;
    logic              adv;

    // winc is registered, so a high winc in WRITE is a write happening now
    assign adv   = (state == WRITE) && winc;
    assign waddr = wptr[ADDRSIZE-1:0];

    always_comb begin
        state_nx = state;
        cnt_nx   = cnt;
        gap_nx   = gap;
        widle_nx = widle;
        winc_nx  = 1'b0;
        unique case (state)
            IDLE: begin
                if (start) begin
                    widle_nx = widle_cfg;
                    cnt_nx   = '0;
                    state_nx = REQ;
                end
            end
            REQ: begin
                if (wack) begin
                    state_nx = WRITE;
                    winc_nx  = !wfull;
                end
            end
            WRITE: begin
                if (winc) begin
                    cnt_nx = cnt + 1'b1;
                    if (cnt == LAST) begin
                        state_nx = DONE;
                    end else if (widle != 2'd0) begin
                        state_nx = GAP;
                        gap_nx   = widle;
                    end else begin
                        winc_nx = !wfull;
                    end
                end else begin
                    winc_nx = !wfull;
                end
            end
            GAP: begin
                gap_nx = gap - 2'd1;
                if (gap <= 2'd1) begin
                    gap_nx   = 2'd0;
                    state_nx = WRITE;
                    winc_nx  = !wfull;
                end
            end
            DONE: begin
                state_nx = IDLE;
            end
            default: begin
                state_nx = IDLE;
            end
        endcase
    end

    always_ff @(posedge wclk or negedge wrst_n) begin
        if (!wrst_n) begin
            state <= IDLE;
            cnt   <= '0;
            gap   <= '0;
            widle <= '0;
            winc  <= 1'b0;
            wen   <= 1'b0;
            busy  <= 1'b0;
            done  <= 1'b0;
            wptr  <= '0;
            wdata <= '0;
        end else begin
            state <= state_nx;
            cnt   <= cnt_nx;
            gap   <= gap_nx;
            widle <= widle_nx;
            winc  <= winc_nx;
            wen   <= (state_nx == REQ) || (state_nx == WRITE) ||
                     (state_nx == GAP);
            busy  <= (state_nx != IDLE);
            done  <= (state_nx == DONE);
            if (adv) begin
                wptr  <= wptr + 1'b1;
                wdata <= wdata + 1'b1;
            end
        end
    end

endmodule

// File: tb/tb_fifo_wr_req.sv
// Directed bench for fifo_wr_req: one 8-word and one 4-word burst instance.
// Covers handshake latency, pacing, stalls, wrap and mid-burst reset.
module tb_fifo_wr_req;

    logic       clk = 1'b0;
    logic       rst_n;
    logic       start8, start4;
    logic [1:0] widle_cfg;
    logic       wack, wfull;

    logic       wen8, winc8, busy8, done8;
    logic [1:0] widle8;
    logic [9:0] waddr8;
    logic [10:0] wptr8;
    logic [7:0] wdata8;

    logic       wen4, winc4, busy4, done4;
    logic [1:0] widle4;
    logic [9:0] waddr4;
    logic [10:0] wptr4;
    logic [7:0] wdata4;

    int n_chk = 0;
    int n_fail = 0;

    always #5 clk = ~clk;

    fifo_wr_req #(.DATASIZE(8), .ADDRSIZE(10), .BURST_LEN(8)) u8 (
        .wclk(clk), .wrst_n(rst_n), .start(start8), .widle_cfg(widle_cfg),
        .wack(wack), .wfull(wfull), .wen(wen8), .widle(widle8),
        .winc(winc8), .waddr(waddr8), .wptr(wptr8), .wdata(wdata8),
        .busy(busy8), .done(done8)
    );

    fifo_wr_req #(.DATASIZE(8), .ADDRSIZE(10), .BURST_LEN(4)) u4 (
        .wclk(clk), .wrst_n(rst_n), .start(start4), .widle_cfg(widle_cfg),
        .wack(wack), .wfull(wfull), .wen(wen4), .widle(widle4),
        .winc(winc4), .waddr(waddr4), .wptr(wptr4), .wdata(wdata4),
        .busy(busy4), .done(done4)
    );

    task automatic tick;
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs,
                       input logic [31:0] exp);
        n_chk++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        logic ok;
        logic tmo;
        int   t;

        rst_n = 1'b0;
        start8 = 1'b0;
        start4 = 1'b0;
        widle_cfg = 2'd0;
        wack = 1'b1;
        wfull = 1'b0;
        #1;
        chk("rst_ctl", {wen8, winc8, busy8, done8, widle8}, 32'h0);
        chk("rst_ptr", {wptr8, waddr8, wdata8}, 32'h0);
        repeat (2) tick;
        rst_n = 1'b1;
        tick;

        // back-to-back burst, wack tied high
        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        chk("t1_wen", {wen8, busy8}, 32'h3);
        chk("t1_req_winc", winc8, 0);
        tick;
        for (int i = 0; i < 8; i++) begin
            chk("t1_write", {winc8, waddr8, wdata8}, {1'b1, 10'(i), 8'(i)});
            tick;
        end
        chk("t1_done", {done8, wen8, winc8}, 32'h4);
        chk("t1_wptr", wptr8, 8);
        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        chk("t1_done_len", {done8, busy8}, 32'h0);
        tick;
        chk("t1_start_in_done", busy8, 0);

        // held-off grant, plus a start while busy
        wack = 1'b0;
        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        ok = 1'b1;
        for (int j = 0; j < 20; j++) begin
            ok &= wen8 && !winc8 && busy8;
            start8 = (j == 5);
            tick;
        end
        start8 = 1'b0;
        chk("t3_req_hold", ok, 1);
        wack = 1'b1;
        tick;
        wack = 1'b0;
        for (int i = 0; i < 8; i++) begin
            chk("t3_write", {winc8, waddr8}, {1'b1, 10'(8 + i)});
            tick;
        end
        chk("t3_done", {done8, wptr8}, {1'b1, 11'd16});
        tick;
        chk("t3_idle", busy8, 0);

        // reset mid-burst
        wack = 1'b1;
        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick;
        repeat (5) tick;
        chk("rb_pre", {winc8, wptr8}, {1'b1, 11'd21});
        rst_n = 1'b0;
        #1;
        chk("rb_ctl", {wen8, winc8, busy8, done8, widle8}, 32'h0);
        chk("rb_ptr", {wptr8, waddr8, wdata8}, 32'h0);
        tick;
        tick;
        rst_n = 1'b1;
        chk("rb_nodone", done8, 0);
        tick;

        // wfull stall after the third write
        start8 = 1'b1;
        tick;
        start8 = 1'b0;
        tick;
        for (int k = 0; k < 3; k++) begin
            chk("t4_write", {winc8, waddr8, wdata8}, {1'b1, 10'(k), 8'(k)});
            if (k == 2) wfull = 1'b1;
            tick;
        end
        ok = 1'b1;
        for (int j = 0; j < 5; j++) begin
            ok &= !winc8 && (waddr8 == 10'd3) && wen8;
            if (j == 4) wfull = 1'b0;
            tick;
        end
        chk("t4_stall", ok, 1);
        for (int k = 3; k < 8; k++) begin
            chk("t4_resume", {winc8, waddr8, wdata8}, {1'b1, 10'(k), 8'(k)});
            tick;
        end
        chk("t4_done", {done8, wptr8, wdata8}, {1'b1, 11'd8, 8'd8});
        tick;

        // paced 4-word burst, widle_cfg changed mid-burst
        widle_cfg = 2'd2;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        widle_cfg = 2'd0;
        tick;
        for (int k = 0; k < 4; k++) begin
            chk("t2_write", {widle4, winc4, waddr4}, {2'd2, 1'b1, 10'(k)});
            if (k == 1) widle_cfg = 2'd3;
            tick;
            if (k < 3) begin
                chk("t2_gap1", {widle4, winc4, wen4}, 32'h9);
                tick;
                chk("t2_gap2", {widle4, winc4, wen4}, 32'h9);
                tick;
            end
        end
        chk("t2_done", {done4, wptr4}, {1'b1, 11'd4});
        tick;

        // walk the 4-word instance up to 1020
        widle_cfg = 2'd0;
        tmo = 1'b0;
        for (int b = 0; b < 254; b++) begin
            start4 = 1'b1;
            tick;
            start4 = 1'b0;
            t = 0;
            while (!done4 && t < 20) begin
                tick;
                t++;
            end
            if (t >= 20) tmo = 1'b1;
            tick;
        end
        chk("pre_timeout", tmo, 0);
        chk("pre_wptr", wptr4, 1020);

        // two bursts across the wrap
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tick;
        for (int k = 0; k < 4; k++) begin
            chk("wr_lo", {winc4, waddr4, wdata4},
                {1'b1, 10'(1020 + k), 8'(252 + k)});
            tick;
        end
        chk("wr_mid", {done4, wptr4}, {1'b1, 11'd1024});
        tick;
        start4 = 1'b1;
        tick;
        start4 = 1'b0;
        tick;
        for (int k = 0; k < 4; k++) begin
            chk("wr_hi", {winc4, waddr4, wdata4}, {1'b1, 10'(k), 8'(k)});
            tick;
        end
        chk("wr_end", {done4, wptr4}, {1'b1, 11'd1028});

        $display("End of test - %0d assertions evaluated, %0d failures",
                 n_chk, n_fail);
        $finish;
    end

endmodule

// File: doc/fifo_wr_req.md
Name: fifo_wr_req

Overview:
- Write-side initiator for the FIFO acknowledgement handshake.
- On a start pulse it raises a write request (wen) and holds it until wack is granted.
- It then streams a burst of BURST_LEN words into FIFO memory with a programmable idle gap between writes, stalling on wfull.
- It maintains the binary write pointer that feeds the acknowledgement block and the memory.

Parameters:
- DATASIZE, 8, write data width.
- ADDRSIZE, 10, address width; FIFO depth is 2**ADDRSIZE = 1024.
- BURST_LEN, 1024, words per burst; range 1..2**ADDRSIZE.

Ports:
- wclk  input  1  write-domain clock.
- wrst_n  input  1  asynchronous active-low reset.
- start  input  1  single-cycle burst launch; honoured only in IDLE.
- widle_cfg  input  2  idle cycles inserted after each write (0..3).
- wack  input  1  write grant from the acknowledgement block.
- wfull  input  1  FIFO full flag in the write domain.
- wen  output  1  write request to the acknowledgement block.
- widle  output  2  latched widle_cfg, presented to the acknowledgement block.
- winc  output  1  memory write strobe, one word per high cycle.
- waddr  output  ADDRSIZE  memory write address.
- wptr  output  ADDRSIZE+1  binary write pointer including the wrap bit.
- wdata  output  DATASIZE  write data.
- busy  output  1  high in any state other than IDLE.
- done  output  1  one-cycle pulse at burst completion.

Behaviour:
- Reset (async assert, sync release):
  - state = IDLE.
  - wen, winc, busy, done = 0.
  - widle = 0, wptr = 0, waddr = 0, wdata = 0.
  - Internal burst counter and gap counter = 0.
  - Reset mid-burst abandons the burst; no done pulse.
- All outputs are registered. waddr = wptr[ADDRSIZE-1:0].
- FSM state IDLE:
  - start=1: latch widle_cfg into widle, clear the burst counter, go to REQ.
  - Otherwise remain.
- FSM state REQ:
  - wen=1 from the first REQ cycle.
  - wack sampled each cycle; wack=1 goes to WRITE next cycle.
  - No timeout; wen holds indefinitely.
- FSM state WRITE:
  - wfull=1: winc=0, stay in WRITE, pointer and data unchanged.
  - wfull=0: winc=1 for this cycle with the current waddr/wdata. At the edge, increment wptr (mod 2**(ADDRSIZE+1)), wdata (mod 2**DATASIZE) and the burst counter.
  - Next state after the edge:
    - counter reaches BURST_LEN: DONE.
    - else widle != 0: GAP, gap counter loaded with widle.
    - else: stay in WRITE (back-to-back writes).
- FSM state GAP:
  - winc=0; decrement the gap counter.
  - Return to WRITE on the cycle the counter reaches 0, giving exactly widle idle cycles between strobes.
  - wfull has no effect in GAP.
- FSM state DONE:
  - done=1 for one cycle, wen=0, then IDLE.
  - busy drops on entering IDLE.
- wen:
  - High in REQ, WRITE and GAP; low in IDLE and DONE.
  - wack is ignored outside REQ; deassertion of wack mid-burst does not stop the burst.
- Wrap-around:
  - waddr wraps 1023→0 while wptr[ADDRSIZE] toggles.
  - wptr and wdata persist across bursts; they are not cleared by start.
- Simultaneous events:
  - start while busy is ignored.
  - start in the DONE cycle is ignored.
  - wfull rising in the same cycle as a winc cycle does not cancel that write; the write was qualified by wfull low at the sampling edge.
- Throughput: widle=n gives one write per n+1 cycles, not counting wfull stalls.
- Latency:
  - start → wen: 1 cycle.
  - wack → first winc: 1 cycle.
  - Last winc → done: 1 cycle.
- widle is stable for the whole burst even if widle_cfg changes.

Test Plan:
- Reset, then start with widle_cfg=0, wack tied 1, wfull=0, BURST_LEN=8:
  - wen rises 1 cycle after start.
  - 8 consecutive winc with waddr 0..7 and wdata 0..7.
  - done pulses once; final wptr=8.
- widle_cfg=2, BURST_LEN=4:
  - winc strobes exactly 3 cycles apart.
  - widle=2 throughout the burst.
  - Changing widle_cfg mid-burst has no effect.
- wack held 0 for 20 cycles after start:
  - wen high and winc 0 for all 20 cycles.
  - First winc 1 cycle after wack rises.
- wfull asserted for 5 cycles after the 3rd write:
  - No winc during the stall; waddr holds at 3.
  - Burst resumes with waddr 3 and completes with no data skipped.
- Preload wptr to 1020 via prior bursts, then run an 8-word burst:
  - waddr sequence 1020..1023,0..3.
  - wptr[10] toggles; final wptr=1028.
- Reset asserted mid-burst after 5 writes:
  - All outputs 0 immediately, no done pulse.
  - A following start begins at wptr=0.
